// File: rtl/raif_rd_rrarb.sv
// raif_rd_rrarb: round-robin arbiter that shares one downstream RAIF read port
// among CHANNEL_NUM upstream read requesters. One transaction is in flight at
// a time. Address and count are latched at grant. Read data is broadcast to
// every channel, and grant/finish are routed only to the owning channel.
module raif_rd_rrarb #(
  parameter int unsigned CHANNEL_NUM    = 3,
  parameter int unsigned APP_ADDR_WIDTH = 28,
  parameter int unsigned APP_DATA_WIDTH = 128,
  parameter int unsigned TIMEOUT        = 4096,
  localparam int unsigned OW            = $clog2(CHANNEL_NUM)
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic [CHANNEL_NUM-1:0]               rd_req_,
  input  logic [APP_ADDR_WIDTH*CHANNEL_NUM-1:0] rd_addr_,
  input  logic [10*CHANNEL_NUM-1:0]            rd_num_,
  output logic [APP_DATA_WIDTH*CHANNEL_NUM-1:0] rd_data_,
  output logic [CHANNEL_NUM-1:0]               rd_grant_,
  output logic [CHANNEL_NUM-1:0]               rd_finish_,
  output logic                                 rd_req,
  output logic [APP_ADDR_WIDTH-1:0]            rd_addr,
  output logic [9:0]                           rd_num,
  input  logic [APP_DATA_WIDTH-1:0]            rd_data,
  input  logic                                 rd_grant,
  input  logic                                 rd_finish,
  output logic [OW-1:0]                        owner,
  output logic                                 busy,
  output logic                                 tmo_err
);

  localparam int unsigned WDW = $clog2(TIMEOUT + 1) + 1;

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  state_t                    state_q, state_d;
  logic [OW-1:0]             ptr_q, ptr_d;
  logic [OW-1:0]             owner_q, owner_d;
  logic                      rd_req_q, rd_req_d;
  logic [APP_ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
  logic [9:0]                rd_num_q, rd_num_d;
  logic                      tmo_err_q, tmo_err_d;
  logic [WDW-1:0]            wd_cnt_q, wd_cnt_d;

  logic                      found;
  logic [OW-1:0]             pick;
  logic [APP_ADDR_WIDTH-1:0] pick_addr;
  logic [9:0]                pick_num;
  logic [OW-1:0]             owner_nxt;
  int unsigned               idx;

  // Round-robin search: first requesting channel starting at ptr, wrapping to 0
  always_comb begin
    found     = 1'b0;
    pick      = '0;
    pick_addr = '0;
    pick_num  = '0;
    idx       = 0;
    for (int unsigned i = 0; i < CHANNEL_NUM; i++) begin
      idx = (32'(ptr_q) + i) % CHANNEL_NUM;
      if (!found && rd_req_[idx]) begin
        found     = 1'b1;
        pick      = OW'(idx);
        pick_addr = rd_addr_[APP_ADDR_WIDTH*idx +: APP_ADDR_WIDTH];
        pick_num  = rd_num_[10*idx +: 10];
      end
    end
  end

  // Pointer value that follows the current owner, modulo CHANNEL_NUM
  always_comb begin
    owner_nxt = owner_q + OW'(1);
    if (32'(owner_q) == CHANNEL_NUM - 1) owner_nxt = '0;
  end

  // Next-state, latch-at-grant and watchdog logic
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    owner_d   = owner_q;
    rd_req_d  = rd_req_q;
    rd_addr_d = rd_addr_q;
    rd_num_d  = rd_num_q;
    tmo_err_d = tmo_err_q;
    wd_cnt_d  = wd_cnt_q;
    case (state_q)
      IDLE: begin
        if (found) begin
          owner_d   = pick;
          rd_addr_d = pick_addr;
          rd_num_d  = pick_num;
          rd_req_d  = 1'b1;
          wd_cnt_d  = '0;
          state_d   = REQ;
        end
      end
      REQ: begin
        if (rd_finish) begin
          rd_req_d = 1'b0;
          ptr_d    = owner_nxt;
          state_d  = DONE;
        end else begin
          if (wd_cnt_q != '1) wd_cnt_d = wd_cnt_q + WDW'(1);
          // wd_cnt_q counts completed stalled cycles, so this edge ends the TIMEOUT-th
          if (TIMEOUT != 0 && 32'(wd_cnt_q) == TIMEOUT - 1) tmo_err_d = 1'b1;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      owner_q   <= '0;
      rd_req_q  <= 1'b0;
      rd_addr_q <= '0;
      rd_num_q  <= '0;
      tmo_err_q <= 1'b0;
      wd_cnt_q  <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      owner_q   <= owner_d;
      rd_req_q  <= rd_req_d;
      rd_addr_q <= rd_addr_d;
      rd_num_q  <= rd_num_d;
      tmo_err_q <= tmo_err_d;
      wd_cnt_q  <= wd_cnt_d;
    end
  end

  // Route grant/finish to the owner only while a transaction is active; broadcast data
  always_comb begin
    rd_grant_  = '0;
    rd_finish_ = '0;
    if (state_q == REQ) begin
      rd_grant_[owner_q]  = rd_grant;
      rd_finish_[owner_q] = rd_finish;
    end
    rd_data_ = {CHANNEL_NUM{rd_data}};
  end

  assign rd_req  = rd_req_q;
  assign rd_addr = rd_addr_q;
  assign rd_num  = rd_num_q;
  assign owner   = owner_q;
  assign busy    = (state_q != IDLE);
  assign tmo_err = tmo_err_q;

endmodule

// File: tb/tb_raif_rd_rrarb.sv
// Testbench for raif_rd_rrarb: directed transactions with expected grants queued
// by the stimulus and checked by an independent monitor.
module tb_raif_rd_rrarb;

  localparam int CH = 3;
  localparam int AW = 28;
  localparam int DW = 128;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [CH-1:0]   req_r;
  logic [AW*CH-1:0] addr_v;
  logic [10*CH-1:0] num_v;
  logic [DW*CH-1:0] rd_data_;
  logic [CH-1:0]   rd_grant_;
  logic [CH-1:0]   rd_finish_;
  logic            rd_req;
  logic [AW-1:0]   rd_addr;
  logic [9:0]      rd_num;
  logic [DW-1:0]   rd_data;
  logic            rd_grant;
  logic            rd_finish;
  logic [1:0]      owner;
  logic            busy;
  logic            tmo_err;

  raif_rd_rrarb #(
    .CHANNEL_NUM   (CH),
    .APP_ADDR_WIDTH(AW),
    .APP_DATA_WIDTH(DW),
    .TIMEOUT       (16)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rd_req_   (req_r),
    .rd_addr_  (addr_v),
    .rd_num_   (num_v),
    .rd_data_  (rd_data_),
    .rd_grant_ (rd_grant_),
    .rd_finish_(rd_finish_),
    .rd_req    (rd_req),
    .rd_addr   (rd_addr),
    .rd_num    (rd_num),
    .rd_data   (rd_data),
    .rd_grant  (rd_grant),
    .rd_finish (rd_finish),
    .owner     (owner),
    .busy      (busy),
    .tmo_err   (tmo_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          ch;
    logic [AW-1:0] addr;
    logic [9:0]  num;
  } txn_t;

  txn_t exp_q[$];
  txn_t cur;
  int   errors = 0;
  int   checks = 0;
  logic prev_req = 1'b0;
  logic [CH-1:0] oh;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic set_ch(input int ch, input logic [AW-1:0] a, input logic [9:0] n);
    addr_v[AW*ch +: AW] = a;
    num_v[10*ch +: 10]  = n;
  endtask

  task automatic expect_txn(input int ch, input logic [AW-1:0] a, input logic [9:0] n);
    txn_t t;
    t.ch = ch; t.addr = a; t.num = n;
    exp_q.push_back(t);
  endtask

  // Downstream responder: len data beats, a finish pulse, then spurious pulses in the gap cycle
  task automatic serve(input int len, input logic [CH-1:0] drop);
    int n;
    n = 0;
    while (!rd_req && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!rd_req) begin
      checks++;
      errors++;
      $display("FAIL serve_wait: rd_req got 0 expected 1 (t=%0t)", $time);
      return;
    end
    for (int i = 0; i < len; i++) begin
      @(posedge clk); #1;
      rd_grant = 1'b1;
      rd_data  = {$urandom(), $urandom(), $urandom(), $urandom()};
    end
    @(posedge clk); #1;
    rd_grant  = 1'b0;
    rd_finish = 1'b1;
    @(posedge clk); #1;
    chk("rd_req_after_finish", 128'(rd_req), 128'(0));
    req_r     = req_r & ~drop;
    rd_grant  = 1'b1;
    rd_finish = 1'b1;
    @(posedge clk); #1;
    rd_grant  = 1'b0;
    rd_finish = 1'b0;
  endtask

  // Monitor: pop expected transaction on each new downstream request; check routing every cycle
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_req = 1'b0;
    end else begin
      if (rd_req && !prev_req) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_txn: owner %0d addr %0h, none expected", owner, rd_addr);
        end else begin
          cur = exp_q.pop_front();
          chk("owner", 128'(owner), 128'(cur.ch));
          chk("rd_addr", 128'(rd_addr), 128'(cur.addr));
          chk("rd_num", 128'(rd_num), 128'(cur.num));
        end
      end
      if (rd_req) begin
        oh = CH'(1) << cur.ch;
        chk("rd_grant_route", 128'(rd_grant_), 128'(rd_grant ? oh : '0));
        chk("rd_finish_route", 128'(rd_finish_), 128'(rd_finish ? oh : '0));
        chk("rd_addr_hold", 128'(rd_addr), 128'(cur.addr));
        chk("rd_num_hold", 128'(rd_num), 128'(cur.num));
      end else begin
        chk("rd_grant_idle", 128'(rd_grant_), 128'(0));
        chk("rd_finish_idle", 128'(rd_finish_), 128'(0));
      end
      chk("rd_data_bcast", 128'(rd_data_ == {CH{rd_data}}), 128'(1));
      prev_req = rd_req;
    end
  end

  initial begin
    #400000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; req_r = '0; addr_v = '0; num_v = '0;
    rd_data = '0; rd_grant = 1'b0; rd_finish = 1'b0;
    #23;
    chk("rst_rd_req", 128'(rd_req), 128'(0));
    chk("rst_rd_addr", 128'(rd_addr), 128'(0));
    chk("rst_rd_num", 128'(rd_num), 128'(0));
    chk("rst_owner", 128'(owner), 128'(0));
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_tmo", 128'(tmo_err), 128'(0));
    chk("rst_grant_", 128'(rd_grant_), 128'(0));
    chk("rst_finish_", 128'(rd_finish_), 128'(0));
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // T1: single request on ch1, one-cycle latency
    set_ch(1, 28'h100, 10'd8);
    req_r = 3'b010;
    expect_txn(1, 28'h100, 10'd8);
    @(negedge clk);
    chk("t1_no_early_req", 128'(rd_req), 128'(0));
    @(posedge clk); #1;
    chk("t1_req_latency", 128'(rd_req), 128'(1));
    chk("t1_busy", 128'(busy), 128'(1));
    serve(8, 3'b010);

    // ch2 alone so the pointer wraps to 0
    set_ch(2, 28'h0abc, 10'd2);
    req_r = 3'b100;
    expect_txn(2, 28'h0abc, 10'd2);
    serve(2, 3'b100);

    // T2: all channels request continuously: 0,1,2,0,1,2
    set_ch(0, 28'h10, 10'd1);
    set_ch(1, 28'h20, 10'd2);
    set_ch(2, 28'h30, 10'd3);
    req_r = 3'b111;
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < CH; c++)
        expect_txn(c, AW'(32'h10 * (c + 1)), 10'(c + 1));
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < CH; c++)
        serve(c + 1, (r == 1 && c == CH - 1) ? 3'b111 : 3'b000);

    // T3: ch0 and ch2 together after ch2 served -> ch0 then ch2
    set_ch(0, 28'h111, 10'd2);
    set_ch(2, 28'h222, 10'd3);
    req_r = 3'b101;
    expect_txn(0, 28'h111, 10'd2);
    expect_txn(2, 28'h222, 10'd3);
    serve(2, 3'b001);
    serve(3, 3'b100);

    // T4: upstream address change during REQ is ignored
    set_ch(0, 28'h40, 10'd4);
    req_r = 3'b001;
    expect_txn(0, 28'h40, 10'd4);
    @(posedge clk); #1;
    set_ch(0, 28'h80, 10'd9);
    serve(4, 3'b001);

    // T5: watchdog fires on the edge ending the 16th stalled REQ cycle
    set_ch(0, 28'h500, 10'd5);
    req_r = 3'b001;
    expect_txn(0, 28'h500, 10'd5);
    @(posedge clk); #1;
    chk("t5_req", 128'(rd_req), 128'(1));
    repeat (15) @(posedge clk);
    #1;
    chk("t5_tmo_before", 128'(tmo_err), 128'(0));
    @(posedge clk); #1;
    chk("t5_tmo_set", 128'(tmo_err), 128'(1));
    repeat (4) @(posedge clk);
    #1;
    chk("t5_tmo_sticky", 128'(tmo_err), 128'(1));
    serve(5, 3'b001);
    chk("t5_tmo_after_finish", 128'(tmo_err), 128'(1));

    // T6: reset during REQ, then ch0 wins over ch1 after release
    set_ch(2, 28'h200, 10'd6);
    req_r = 3'b100;
    expect_txn(2, 28'h200, 10'd6);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rd_grant = 1'b1;
    @(negedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_req", 128'(rd_req), 128'(0));
    chk("t6_rst_busy", 128'(busy), 128'(0));
    chk("t6_rst_grant_", 128'(rd_grant_), 128'(0));
    chk("t6_rst_owner", 128'(owner), 128'(0));
    chk("t6_rst_tmo", 128'(tmo_err), 128'(0));
    rd_grant = 1'b0;
    set_ch(0, 28'h300, 10'd2);
    set_ch(1, 28'h400, 10'd3);
    req_r = 3'b011;
    expect_txn(0, 28'h300, 10'd2);
    expect_txn(1, 28'h400, 10'd3);
    @(negedge clk); #2;
    rst_n = 1'b1;
    serve(2, 3'b001);
    serve(3, 3'b010);

    repeat (3) @(posedge clk);
    #1;
    chk("pending_txns", 128'(exp_q.size()), 128'(0));
    chk("final_idle", 128'(busy), 128'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
